fetch_sequencer: RTL and testbench

//  Multi-cycle fetch controller that sequences the program counter and instruction memory.
//  - Issues one imem read per PC value using a req/ack handshake.
//  - Latches the returned word into an instruction register and hands it to decode (valid/ready).
//  - Pulses pc_advance so the PC register steps exactly once per accepted fetch.
//  - Squashes in-flight or held fetches on a jump/branch redirect.

---
 rtl/fetch_sequencer_pkg.sv | 22 ++
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/fetch_sequencer_wait_timer.sv | 26 ++
 rtl/fetch_sequencer.sv | 159 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared widths, fetch state encoding and address helpers for the fetch sequencer.
package fetch_sequencer_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned FETCH_CNT_W = 16;
    localparam int unsigned TIMER_W     = 8;
    localparam int unsigned STATE_W     = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_HOLD     = 3'd3,
        ST_FAULT    = 3'd4
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read channel plus the instruction handoff to decode.
interface fetch_sequencer_if import fetch_sequencer_pkg::*; #(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_ack, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_ack, imem_rdata, instr_ready
    );

endinterface

// File: rtl/fetch_sequencer_wait_timer.sv
// Counts consecutive cycles spent waiting on imem_ack; flags the last allowed cycle.
module fetch_sequencer_wait_timer import fetch_sequencer_pkg::*; #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + TIMER_W'(1);
        end
    end

    assign expired_c = enable && (count_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: issues one imem read per PC, buffers the word for decode, steps the PC.
module fetch_sequencer import fetch_sequencer_pkg::*; #(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      pc_addr,
    output logic                   pc_advance,
    input  logic                   redirect,
    input  logic                   stall,
    fetch_sequencer_if.master      bus,
    output logic [FETCH_CNT_W-1:0] fetch_count,
    output logic                   fault
);

    fetch_state_e            state_q, state_d;
    logic                    req_q, req_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       instr_q, instr_d;
    logic                    valid_q, valid_d;
    logic                    adv_q, adv_d;
    logic [FETCH_CNT_W-1:0]  cnt_q, cnt_d;
    logic                    fault_q, fault_d;
    logic                    squash_q, squash_d;

    logic timer_clear, timer_enable, timer_expired;
    logic accept, aligned, drop_ack;

    assign accept       = valid_q && bus.instr_ready;
    assign aligned      = is_word_aligned(pc_addr[1:0]);
    // An ack is discarded if a redirect arrived earlier in the wait or lands with it.
    assign drop_ack     = squash_q || redirect;
    assign timer_clear  = (state_q != ST_WAIT_ACK);
    assign timer_enable = (state_q == ST_WAIT_ACK) && !bus.imem_ack;

    fetch_sequencer_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (timer_clear),
        .enable    (timer_enable),
        .expired_c (timer_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (!stall) state_d = aligned ? ST_WAIT_ACK : ST_FAULT;
            end
            ST_WAIT_ACK: begin
                if (bus.imem_ack)       state_d = drop_ack ? ST_ISSUE : ST_HOLD;
                else if (timer_expired) state_d = ST_FAULT;
            end
            ST_HOLD: begin
                if (redirect || ((!valid_q || bus.instr_ready) && !stall)) state_d = ST_ISSUE;
            end
            ST_FAULT:    state_d = ST_FAULT;
            default:     state_d = ST_FAULT;
        endcase
    end

    // Next values of every registered output.
    always_comb begin
        req_d    = req_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        adv_d    = 1'b0;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        squash_d = squash_q;
        case (state_q)
            ST_ISSUE: begin
                req_d = 1'b0;
                if (!stall) begin
                    if (!aligned) begin
                        fault_d = 1'b1;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = pc_addr;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (bus.imem_ack) begin
                    req_d = 1'b0;
                    if (drop_ack) begin
                        squash_d = 1'b0;
                    end else begin
                        instr_d = bus.imem_rdata;
                        valid_d = 1'b1;
                        adv_d   = 1'b1;
                    end
                end else begin
                    if (redirect) squash_d = 1'b1;
                    if (timer_expired) begin
                        fault_d = 1'b1;
                        req_d   = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    cnt_d   = cnt_q + FETCH_CNT_W'(1);
                    valid_d = 1'b0;
                end
                if (redirect) valid_d = 1'b0;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q    <= 1'b0;
            addr_q   <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            adv_q    <= 1'b0;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
            squash_q <= 1'b0;
        end else begin
            req_q    <= req_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            adv_q    <= adv_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            squash_q <= squash_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign pc_advance      = adv_q;
    assign fetch_count     = cnt_q;
    assign fault           = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized fetch transactions checked against a transaction-level model.
module tb_fetch_sequencer;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_advance;
    logic              redirect;
    logic              stall;
    logic [15:0]       fetch_count;
    logic              fault;

    fetch_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_addr     (pc_addr),
        .pc_advance  (pc_advance),
        .redirect    (redirect),
        .stall       (stall),
        .bus         (bus),
        .fetch_count (fetch_count),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          adv_seen = 0;
    int          exp_adv = 0;
    logic [15:0] exp_cnt = '0;
    logic        adv_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every pc_advance pulse is counted; two in a row is an error.
    always @(posedge clk) begin
        if (pc_advance === 1'b1) begin
            adv_seen++;
            checks++;
            assert (adv_prev === 1'b0) else begin
                errors++;
                $error("FAIL adv_consecutive observed=1 expected=0");
            end
        end
        adv_prev = pc_advance;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.imem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("req_timeout", 64'(bus.imem_req), 64'(1));
    endtask

    // One fetch: mode 0 none, 1 redirect the cycle before ack, 2 redirect with ack.
    task automatic fetch(input logic [31:0] addr, input int lat, input int rdy_wait,
                         input int redir_mode, input logic [31:0] tgt, input int stall_hold,
                         input bit hold_redir, input bit hold_rdy, output bit squashed);
        bit          ok;
        int          mode;
        logic [31:0] data;
        squashed = 1'b0;
        mode     = (redir_mode == 1 && lat < 2) ? 2 : redir_mode;
        pc_addr  = addr;
        wait_req(ok);
        if (!ok) return;
        check("req_addr", 64'(bus.imem_addr), 64'(addr));
        for (int i = 1; i < lat; i++) begin
            stall = 1'($urandom_range(0, 1));
            if (mode == 1 && i == lat - 1) begin
                redirect = 1'b1;
                pc_addr  = tgt;
            end
            tick();
            redirect = 1'b0;
            check("req_held", 64'(bus.imem_req), 64'(1));
            check("addr_held", 64'(bus.imem_addr), 64'(addr));
        end
        stall          = 1'b0;
        data           = $urandom;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        if (mode == 2) begin
            redirect = 1'b1;
            pc_addr  = tgt;
        end
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        redirect       = 1'b0;
        check("req_drop", 64'(bus.imem_req), 64'(0));
        if (mode != 0) begin
            squashed = 1'b1;
            check("squash_valid", 64'(bus.instr_valid), 64'(0));
            check("squash_adv", 64'(pc_advance), 64'(0));
            return;
        end
        exp_adv++;
        check("adv_pulse", 64'(pc_advance), 64'(1));
        check("valid_set", 64'(bus.instr_valid), 64'(1));
        check("instr", 64'(bus.instr), 64'(data));
        for (int i = 0; i < rdy_wait; i++) begin
            tick();
            check("adv_once", 64'(pc_advance), 64'(0));
            check("hold_valid", 64'(bus.instr_valid), 64'(1));
            check("hold_instr", 64'(bus.instr), 64'(data));
            check("hold_no_req", 64'(bus.imem_req), 64'(0));
        end
        if (hold_redir) begin
            redirect        = 1'b1;
            bus.instr_ready = hold_rdy;
            exp_cnt         = exp_cnt + 16'(hold_rdy);
            tick();
            redirect        = 1'b0;
            bus.instr_ready = 1'b0;
            check("redir_valid", 64'(bus.instr_valid), 64'(0));
        end else begin
            bus.instr_ready = 1'b1;
            stall           = (stall_hold > 0);
            exp_cnt         = exp_cnt + 16'(1);
            tick();
            bus.instr_ready = 1'b0;
            check("accept_valid", 64'(bus.instr_valid), 64'(0));
            for (int i = 1; i < stall_hold; i++) begin
                tick();
                check("stall_no_req", 64'(bus.imem_req), 64'(0));
                check("stall_valid", 64'(bus.instr_valid), 64'(0));
            end
            stall = 1'b0;
        end
        check("fetch_count", 64'(fetch_count), 64'(exp_cnt));
        check("adv_total", 64'(adv_seen), 64'(exp_adv));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 64'(bus.imem_req), 64'(0));
        check({tag, "_addr"}, 64'(bus.imem_addr), 64'(0));
        check({tag, "_instr"}, 64'(bus.instr), 64'(0));
        check({tag, "_valid"}, 64'(bus.instr_valid), 64'(0));
        check({tag, "_adv"}, 64'(pc_advance), 64'(0));
        check({tag, "_count"}, 64'(fetch_count), 64'(0));
        check({tag, "_fault"}, 64'(fault), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        bit          sq;
        logic [31:0] addr;
        logic [31:0] tgt;
        int          mode;

        reset           = 1'b1;
        stall           = 1'b0;
        redirect        = 1'b0;
        pc_addr         = 32'h0040_0000;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        #2 reset = 1'b0;
        #1 check_all_zero("reset");
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("idle_no_req", 64'(bus.imem_req), 64'(0));
        tick();
        check("first_req", 64'(bus.imem_req), 64'(1));

        // Basic fetch, ack on the third wait cycle, decode ready at once.
        fetch(32'h0040_0000, 3, 0, 0, '0, 0, 1'b0, 1'b0, sq);
        pc_addr = 32'h0040_0004;
        check("ack2req_gap", 64'(bus.imem_req), 64'(0));
        tick();
        check("ack2req_req", 64'(bus.imem_req), 64'(1));

        // Decode holds off for five cycles.
        fetch(32'h0040_0004, 2, 5, 0, '0, 0, 1'b0, 1'b0, sq);

        // Redirect the cycle before ack; the next request must use the target.
        fetch(32'h0040_0008, 3, 0, 1, 32'h0040_0100, 0, 1'b0, 1'b0, sq);
        check("squashed", 64'(sq), 64'(1));
        fetch(32'h0040_0100, 1, 0, 0, '0, 0, 1'b0, 1'b0, sq);

        addr = 32'h0040_0104;
        for (int n = 0; n < 30; n++) begin
            mode = $urandom_range(0, 5);
            if (mode > 2) mode = 0;
            tgt = $urandom & 32'hFFFF_FFFC;
            fetch(addr, $urandom_range(1, 10), $urandom_range(0, 3), mode, tgt,
                  $urandom_range(0, 3), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), sq);
            addr = sq ? tgt : ($urandom & 32'hFFFF_FFFC);
        end

        // Reset while a request is outstanding; a late ack must be ignored.
        pc_addr = 32'h0040_0040;
        wait_req(ok);
        reset = 1'b0;
        #1 check_all_zero("midreset");
        exp_cnt = '0;
        tick();
        tick();
        reset        = 1'b1;
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        check("late_ack_req", 64'(bus.imem_req), 64'(0));
        check("late_ack_valid", 64'(bus.instr_valid), 64'(0));
        tick();
        check("rereq", 64'(bus.imem_req), 64'(1));
        check("rereq_valid", 64'(bus.instr_valid), 64'(0));
        fetch(32'h0040_0040, 2, 1, 0, '0, 0, 1'b0, 1'b0, sq);

        // Ack never returns.
        pc_addr = 32'h0040_0200;
        wait_req(ok);
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            tick();
            check("wait_no_fault", 64'(fault), 64'(0));
            check("wait_req", 64'(bus.imem_req), 64'(1));
        end
        tick();
        check("timeout_fault", 64'(fault), 64'(1));
        check("timeout_req", 64'(bus.imem_req), 64'(0));
        check("timeout_valid", 64'(bus.instr_valid), 64'(0));
        for (int i = 0; i < 4; i++) begin
            redirect     = 1'($urandom_range(0, 1));
            bus.imem_ack = 1'($urandom_range(0, 1));
            tick();
            check("fault_sticky", 64'(fault), 64'(1));
            check("fault_no_req", 64'(bus.imem_req), 64'(0));
        end
        redirect     = 1'b0;
        bus.imem_ack = 1'b0;
        reset        = 1'b0;
        #1 check("fault_cleared", 64'(fault), 64'(0));
        check("adv_after_fault", 64'(adv_seen), 64'(exp_adv));
        tick();

        // Misaligned PC faults without issuing a request.
        pc_addr = 32'h0040_0002;
        reset   = 1'b1;
        tick();
        check("mis_idle_req", 64'(bus.imem_req), 64'(0));
        check("mis_idle_fault", 64'(fault), 64'(0));
        tick();
        check("mis_fault", 64'(fault), 64'(1));
        check("mis_no_req", 64'(bus.imem_req), 64'(0));
        tick();
        check("mis_stays", 64'(fault), 64'(1));
        check("mis_still_no_req", 64'(bus.imem_req), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
